// File: rtl/atom_kbd_pkg.sv
// Shared constants, state encodings and helpers for the Atom PS/2 keyboard responder.
// Optional build macro used by this slice: ATOM_KBD_BREAK_EN.
package atom_kbd_pkg;

  localparam int ROWS = 10;
  localparam int COLS = 6;

  localparam logic [7:0] SC_RELEASE = 8'hF0;
  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_PAUSE   = 8'hE1;
  localparam logic [7:0] SC_LSHIFT  = 8'h12;
  localparam logic [7:0] SC_RSHIFT  = 8'h59;
  localparam logic [7:0] SC_CTRL    = 8'h14;
  localparam logic [7:0] SC_ALT     = 8'h11;
  localparam logic [7:0] SC_F10     = 8'h09;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

  typedef enum logic [1:0] {
    MOD_NONE,
    MOD_SHIFT,
    MOD_CTRL,
    MOD_REPT
  } mod_sel_t;

  function automatic logic odd_parity(input logic [8:0] bits);
    return ^bits;
  endfunction

  function automatic logic [6:0] rc(input int r, input int c);
    return {4'(r), 3'(c)};
  endfunction

endpackage

// File: rtl/atom_keyboard_if.sv
// PIA-side keyboard bus: row select from PA, column return and modifiers to PB, scan strobe.
// break_n exists only when ATOM_KBD_BREAK_EN is defined.
interface atom_keyboard_if;
  import atom_kbd_pkg::*;

  logic [3:0]      row;
  logic [COLS-1:0] keyout;
  logic            shift_n;
  logic            ctrl_n;
  logic            rept_n;
  logic            scan_valid;
  logic [7:0]      scan_code;
`ifdef ATOM_KBD_BREAK_EN
  logic            break_n;

  modport master (output row, input keyout, shift_n, ctrl_n, rept_n, scan_valid, scan_code, break_n);
  modport slave  (input row, output keyout, shift_n, ctrl_n, rept_n, scan_valid, scan_code, break_n);
`else
  modport master (output row, input keyout, shift_n, ctrl_n, rept_n, scan_valid, scan_code);
  modport slave  (input row, output keyout, shift_n, ctrl_n, rept_n, scan_valid, scan_code);
`endif

endinterface

// File: rtl/atom_keymap.sv
// PS/2 set-2 scancode to Atom matrix position / modifier lookup, keyed on {extended, code}.
// F10 (09) is deliberately absent; the top handles it only when ATOM_KBD_BREAK_EN is defined.
module atom_keymap
  import atom_kbd_pkg::*;
(
  input  logic [8:0] code,
  output logic       hit,
  output logic [3:0] row,
  output logic [2:0] col,
  output mod_sel_t   mod_sel
);

  always_comb begin
    hit        = 1'b1;
    {row, col} = 7'h00;
    mod_sel    = MOD_NONE;
    case (code)
      {1'b0, SC_LSHIFT}, {1'b0, SC_RSHIFT}: mod_sel = MOD_SHIFT;
      {1'b0, SC_CTRL},   {1'b1, SC_CTRL}:   mod_sel = MOD_CTRL;
      {1'b0, SC_ALT}:                       mod_sel = MOD_REPT;
      // column 5
      9'h01C: {row, col} = rc(3, 5);   9'h032: {row, col} = rc(4, 5);
      9'h021: {row, col} = rc(5, 5);   9'h023: {row, col} = rc(6, 5);
      9'h024: {row, col} = rc(7, 5);   9'h02B: {row, col} = rc(8, 5);
      9'h034: {row, col} = rc(9, 5);
      // column 4
      9'h033: {row, col} = rc(0, 4);   9'h043: {row, col} = rc(1, 4);
      9'h03B: {row, col} = rc(2, 4);   9'h042: {row, col} = rc(3, 4);
      9'h04B: {row, col} = rc(4, 4);   9'h03A: {row, col} = rc(5, 4);
      9'h031: {row, col} = rc(6, 4);   9'h044: {row, col} = rc(7, 4);
      9'h04D: {row, col} = rc(8, 4);   9'h015: {row, col} = rc(9, 4);
      // column 3
      9'h02D: {row, col} = rc(0, 3);   9'h01B: {row, col} = rc(1, 3);
      9'h02C: {row, col} = rc(2, 3);   9'h03C: {row, col} = rc(3, 3);
      9'h02A: {row, col} = rc(4, 3);   9'h01D: {row, col} = rc(5, 3);
      9'h022: {row, col} = rc(6, 3);   9'h035: {row, col} = rc(7, 3);
      9'h01A: {row, col} = rc(8, 3);   9'h054: {row, col} = rc(9, 3);
      // column 2, including cursor up/down
      9'h045: {row, col} = rc(0, 2);   9'h016: {row, col} = rc(1, 2);
      9'h01E: {row, col} = rc(2, 2);   9'h026: {row, col} = rc(3, 2);
      9'h025: {row, col} = rc(4, 2);   9'h175: {row, col} = rc(5, 2);
      9'h172: {row, col} = rc(6, 2);   9'h02E: {row, col} = rc(7, 2);
      9'h036: {row, col} = rc(8, 2);   9'h03D: {row, col} = rc(9, 2);
      // column 1, including cursor left/right
      9'h03E: {row, col} = rc(0, 1);   9'h046: {row, col} = rc(1, 1);
      9'h04E: {row, col} = rc(2, 1);   9'h04C: {row, col} = rc(3, 1);
      9'h066: {row, col} = rc(4, 1);   9'h16B: {row, col} = rc(5, 1);
      9'h05A: {row, col} = rc(6, 1);   9'h174: {row, col} = rc(7, 1);
      9'h041: {row, col} = rc(8, 1);   9'h049: {row, col} = rc(9, 1);
      // column 0, space on row 9
      9'h076: {row, col} = rc(0, 0);   9'h04A: {row, col} = rc(1, 0);
      9'h05B: {row, col} = rc(2, 0);   9'h052: {row, col} = rc(3, 0);
      9'h055: {row, col} = rc(4, 0);   9'h05D: {row, col} = rc(5, 0);
      9'h171: {row, col} = rc(6, 0);   9'h00D: {row, col} = rc(7, 0);
      9'h00E: {row, col} = rc(8, 0);   9'h029: {row, col} = rc(9, 0);
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/atom_keyboard.sv
// PS/2 receiver, scancode decoder and 10x6 key matrix answering the Atom PIA row scan.
// Define ATOM_KBD_BREAK_EN to add kbd.break_n, held low while F10 is down.
//
// state     | meaning
// ST_IDLE   | waiting for a start bit (data=0 at a filtered clock fall)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the parity bit
// ST_STOP   | checking stop bit and odd parity, then back to idle
module atom_keyboard
  import atom_kbd_pkg::*;
#(
  parameter int CLKSPEED = 25_000_000,
  parameter int FILTER   = 8,
  parameter int TIMEOUT  = CLKSPEED / 5000
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  atom_keyboard_if.slave kbd
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync, data_sync;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          sample_evt;
  logic          data_s;

  frame_state_t  state, state_nx;
  logic [2:0]    bit_cnt, bit_cnt_nx;
  logic [7:0]    shreg, shreg_nx;
  logic          par, par_nx;
  logic [TW-1:0] tmo_cnt;
  logic          timeout;
  logic          byte_ok;

  logic          scan_valid;
  logic [7:0]    scan_code;

  logic                 rel_flag, ext_flag;
  logic [2:0]           pause_cnt;
  logic [ROWS-1:0][COLS-1:0] matrix;
  logic [1:0]           shift_held;
  logic [1:0]           ctrl_held;
  logic                 alt_held;
  logic                 km_hit;
  logic [3:0]           km_row;
  logic [2:0]           km_col;
  mod_sel_t             km_mod;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign data_s = data_sync[1];

  // Level flips only after FILTER consecutive samples disagree with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_filt <= 1'b1;
      filt_cnt <= FW'(FILTER - 1);
    end else if (clk_sync[1] == clk_filt) begin
      filt_cnt <= FW'(FILTER - 1);
    end else if (filt_cnt == '0) begin
      clk_filt <= clk_sync[1];
      filt_cnt <= FW'(FILTER - 1);
    end else begin
      filt_cnt <= filt_cnt - 1'b1;
    end
  end

  assign sample_evt = clk_filt && !clk_sync[1] && (filt_cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= TW'(TIMEOUT - 1);
    end else if (state == ST_IDLE || sample_evt) begin
      tmo_cnt <= TW'(TIMEOUT - 1);
    end else if (tmo_cnt != '0) begin
      tmo_cnt <= tmo_cnt - 1'b1;
    end
  end

  assign timeout = (state != ST_IDLE) && (tmo_cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      shreg   <= shreg_nx;
      par     <= par_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    par_nx     = par;
    byte_ok    = 1'b0;
    if (sample_evt) begin
      case (state)
        ST_IDLE: begin
          if (!data_s) begin
            state_nx   = ST_DATA;
            bit_cnt_nx = '0;
          end
        end
        ST_DATA: begin
          shreg_nx   = {data_s, shreg[7:1]};
          bit_cnt_nx = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_nx = ST_PARITY;
        end
        ST_PARITY: begin
          par_nx   = data_s;
          state_nx = ST_STOP;
        end
        ST_STOP: begin
          byte_ok  = data_s && odd_parity({par, shreg});
          state_nx = ST_IDLE;
        end
        default: state_nx = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_nx = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_valid <= 1'b0;
      scan_code  <= 8'h00;
    end else begin
      scan_valid <= byte_ok;
      if (byte_ok) scan_code <= shreg;
    end
  end

  atom_keymap u_keymap (
    .code    ({ext_flag, scan_code}),
    .hit     (km_hit),
    .row     (km_row),
    .col     (km_col),
    .mod_sel (km_mod)
  );

`ifdef ATOM_KBD_BREAK_EN
  logic break_held;
`endif

  // Decoding runs in the scan_valid cycle, so the matrix changes one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rel_flag   <= 1'b0;
      ext_flag   <= 1'b0;
      pause_cnt  <= '0;
      matrix     <= '0;
      shift_held <= '0;
      ctrl_held  <= '0;
      alt_held   <= 1'b0;
`ifdef ATOM_KBD_BREAK_EN
      break_held <= 1'b0;
`endif
    end else if (scan_valid) begin
      if (pause_cnt != '0) begin
        pause_cnt <= pause_cnt - 1'b1;
      end else if (scan_code == SC_RELEASE) begin
        rel_flag <= 1'b1;
      end else if (scan_code == SC_EXT) begin
        ext_flag <= 1'b1;
      end else if (scan_code == SC_PAUSE) begin
        pause_cnt <= 3'd7;
        rel_flag  <= 1'b0;
        ext_flag  <= 1'b0;
      end else begin
        rel_flag <= 1'b0;
        ext_flag <= 1'b0;
        if (km_hit) begin
          case (km_mod)
            MOD_SHIFT: shift_held[scan_code == SC_RSHIFT] <= !rel_flag;
            MOD_CTRL:  ctrl_held[ext_flag] <= !rel_flag;
            MOD_REPT:  alt_held <= !rel_flag;
            default: begin
              if (km_row < 4'(ROWS) && km_col < 3'(COLS))
                matrix[km_row][km_col] <= !rel_flag;
            end
          endcase
        end
`ifdef ATOM_KBD_BREAK_EN
        if (scan_code == SC_F10 && !ext_flag) break_held <= !rel_flag;
`endif
      end
    end
  end

  assign kbd.keyout     = (kbd.row < 4'(ROWS)) ? ~matrix[kbd.row] : {COLS{1'b1}};
  assign kbd.shift_n    = ~|shift_held;
  assign kbd.ctrl_n     = ~|ctrl_held;
  assign kbd.rept_n     = ~alt_held;
  assign kbd.scan_valid = scan_valid;
  assign kbd.scan_code  = scan_code;
`ifdef ATOM_KBD_BREAK_EN
  assign kbd.break_n    = ~break_held;
`endif

endmodule

// File: tb/tb_atom_keyboard.sv
// Directed bench for atom_keyboard: PS/2 frames in, matrix readback and modifiers checked.
module tb_atom_keyboard;

  localparam int CLKSPEED = 1_000_000;
  localparam int FILTER   = 8;
  localparam int TIMEOUT  = CLKSPEED / 5000;
  localparam int HALF     = 20;

  logic clk      = 1'b0;
  logic reset_n  = 1'b0;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;

  int errors = 0;
  int checks = 0;

  int         valid_cnt   = 0;
  logic [7:0] last_code   = 8'h00;
  logic [5:0] kv_at_valid = 6'h00;
  logic [5:0] kv_after    = 6'h00;
  logic       prev_valid  = 1'b0;

  atom_keyboard_if kbd ();

  atom_keyboard #(
    .CLKSPEED (CLKSPEED),
    .FILTER   (FILTER),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .kbd      (kbd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (prev_valid) kv_after = kbd.keyout;
    if (kbd.scan_valid) begin
      valid_cnt++;
      last_code   = kbd.scan_code;
      kv_at_valid = kbd.keyout;
    end
    prev_valid = kbd.scan_valid;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_clk(HALF);
    ps2_clk = 1'b0;
    wait_clk(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(~bad_stop);
    ps2_data = 1'b1;
    wait_clk(3 * HALF);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    kbd.row = 4'd0;
    reset_n = 1'b0;
    wait_clk(5);
    @(negedge clk);
    checks++; if (kbd.keyout !== 6'h3F) begin errors++; $display("FAIL reset_keyout: got %h want 3f", kbd.keyout); end
    checks++; if (kbd.shift_n !== 1'b1) begin errors++; $display("FAIL reset_shift_n: got %b want 1", kbd.shift_n); end
    checks++; if (kbd.ctrl_n !== 1'b1) begin errors++; $display("FAIL reset_ctrl_n: got %b want 1", kbd.ctrl_n); end
    checks++; if (kbd.rept_n !== 1'b1) begin errors++; $display("FAIL reset_rept_n: got %b want 1", kbd.rept_n); end
    checks++; if (kbd.scan_valid !== 1'b0) begin errors++; $display("FAIL reset_scan_valid: got %b want 0", kbd.scan_valid); end
    checks++; if (kbd.scan_code !== 8'h00) begin errors++; $display("FAIL reset_scan_code: got %h want 00", kbd.scan_code); end
    @(posedge clk);
    reset_n = 1'b1;
    wait_clk(20);
  endtask

  task automatic test_press;
    int v0;
    kbd.row = 4'd3;
    v0 = valid_cnt;
    send(8'h1C);
    @(negedge clk);
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL press_valid_count: got %0d want %0d", valid_cnt, v0 + 1); end
    checks++; if (last_code !== 8'h1C) begin errors++; $display("FAIL press_scan_code: got %h want 1c", last_code); end
    checks++; if (kv_at_valid !== 6'h3F) begin errors++; $display("FAIL press_keyout_at_strobe: got %h want 3f", kv_at_valid); end
    checks++; if (kv_after !== 6'h1F) begin errors++; $display("FAIL press_keyout_after_strobe: got %h want 1f", kv_after); end
    checks++; if (kbd.keyout !== 6'h1F) begin errors++; $display("FAIL press_row3: got %h want 1f", kbd.keyout); end
    kbd.row = 4'd4;
    @(negedge clk);
    checks++; if (kbd.keyout !== 6'h3F) begin errors++; $display("FAIL press_row4: got %h want 3f", kbd.keyout); end
    kbd.row = 4'd12;
    @(negedge clk);
    checks++; if (kbd.keyout !== 6'h3F) begin errors++; $display("FAIL press_row12: got %h want 3f", kbd.keyout); end
  endtask

  task automatic test_release;
    kbd.row = 4'd3;
    send(8'h1C);
    @(negedge clk);
    checks++; if (kbd.keyout !== 6'h1F) begin errors++; $display("FAIL typematic_row3: got %h want 1f", kbd.keyout); end
    send(8'hF0); send(8'h1C);
    @(negedge clk);
    checks++; if (kbd.keyout !== 6'h3F) begin errors++; $display("FAIL release_row3: got %h want 3f", kbd.keyout); end
    send(8'h12);
    @(negedge clk);
    checks++; if (kbd.shift_n !== 1'b0) begin errors++; $display("FAIL lshift_press: got %b want 0", kbd.shift_n); end
    send(8'h59); send(8'hF0); send(8'h12);
    @(negedge clk);
    checks++; if (kbd.shift_n !== 1'b0) begin errors++; $display("FAIL rshift_still_held: got %b want 0", kbd.shift_n); end
    send(8'hF0); send(8'h59);
    @(negedge clk);
    checks++; if (kbd.shift_n !== 1'b1) begin errors++; $display("FAIL shift_release: got %b want 1", kbd.shift_n); end
    send(8'hE0); send(8'h14);
    @(negedge clk);
    checks++; if (kbd.ctrl_n !== 1'b0) begin errors++; $display("FAIL rctrl_press: got %b want 0", kbd.ctrl_n); end
    checks++; if (kbd.keyout !== 6'h3F) begin errors++; $display("FAIL rctrl_no_matrix: got %h want 3f", kbd.keyout); end
    send(8'hE0); send(8'hF0); send(8'h14);
    @(negedge clk);
    checks++; if (kbd.ctrl_n !== 1'b1) begin errors++; $display("FAIL rctrl_release: got %b want 1", kbd.ctrl_n); end
    send(8'h11);
    @(negedge clk);
    checks++; if (kbd.rept_n !== 1'b0) begin errors++; $display("FAIL alt_press: got %b want 0", kbd.rept_n); end
    send(8'hF0); send(8'h11);
    @(negedge clk);
    checks++; if (kbd.rept_n !== 1'b1) begin errors++; $display("FAIL alt_release: got %b want 1", kbd.rept_n); end
  endtask

  task automatic test_bad_frames;
    int v0;
    kbd.row = 4'd9;
    v0 = valid_cnt;
    send_frame(8'h29, 1'b1, 1'b0);
    send_frame(8'h29, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL bad_frames_valid_count: got %0d want %0d", valid_cnt, v0); end
    checks++; if (kbd.keyout !== 6'h3F) begin errors++; $display("FAIL bad_frames_row9: got %h want 3f", kbd.keyout); end
  endtask

  task automatic test_timeout;
    int v0;
    kbd.row = 4'd9;
    v0 = valid_cnt;
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    ps2_data = 1'b1;
    wait_clk(TIMEOUT + 100);
    send(8'h29);
    @(negedge clk);
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL timeout_valid_count: got %0d want %0d", valid_cnt, v0 + 1); end
    checks++; if (last_code !== 8'h29) begin errors++; $display("FAIL timeout_scan_code: got %h want 29", last_code); end
    checks++; if (kbd.keyout !== 6'h3E) begin errors++; $display("FAIL timeout_row9: got %h want 3e", kbd.keyout); end
  endtask

  task automatic test_extended;
    logic [7:0] pause_seq [8];
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    kbd.row = 4'd5;
    send(8'hE0); send(8'h75);
    @(negedge clk);
    checks++; if (kbd.keyout !== 6'h3B) begin errors++; $display("FAIL ext_up_row5: got %h want 3b", kbd.keyout); end
    send(8'h75);
    @(negedge clk);
    checks++; if (last_code !== 8'h75) begin errors++; $display("FAIL kp8_scan_code: got %h want 75", last_code); end
    checks++; if (kbd.keyout !== 6'h3B) begin errors++; $display("FAIL kp8_row5: got %h want 3b", kbd.keyout); end
    for (int i = 0; i < 8; i++) send(pause_seq[i]);
    @(negedge clk);
    checks++; if (kbd.ctrl_n !== 1'b1) begin errors++; $display("FAIL pause_ctrl_n: got %b want 1", kbd.ctrl_n); end
    checks++; if (kbd.keyout !== 6'h3B) begin errors++; $display("FAIL pause_row5: got %h want 3b", kbd.keyout); end
    kbd.row = 4'd9;
    send(8'hF0); send(8'h29);
    @(negedge clk);
    checks++; if (kbd.keyout !== 6'h3F) begin errors++; $display("FAIL after_pause_release_row9: got %h want 3f", kbd.keyout); end
  endtask

  task automatic test_glitch;
    int v0;
    kbd.row = 4'd4;
    v0 = valid_cnt;
    ps2_data = 1'b0;
    repeat (3) begin
      ps2_clk = 1'b0;
      wait_clk(3);
      ps2_clk = 1'b1;
      wait_clk(10);
    end
    ps2_data = 1'b1;
    send(8'h32);
    @(negedge clk);
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL glitch_valid_count: got %0d want %0d", valid_cnt, v0 + 1); end
    checks++; if (last_code !== 8'h32) begin errors++; $display("FAIL glitch_scan_code: got %h want 32", last_code); end
    checks++; if (kbd.keyout !== 6'h1F) begin errors++; $display("FAIL glitch_row4: got %h want 1f", kbd.keyout); end
    send(8'hF0); send(8'h32);
  endtask

  task automatic test_reset_mid_frame;
    kbd.row = 4'd5;
    send(8'h12);
    send(8'hE0);
    @(negedge clk);
    checks++; if (kbd.keyout !== 6'h3B) begin errors++; $display("FAIL pre_reset_row5: got %h want 3b", kbd.keyout); end
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    reset_n = 1'b0;
    wait_clk(3);
    @(negedge clk);
    checks++; if (kbd.keyout !== 6'h3F) begin errors++; $display("FAIL midreset_row5: got %h want 3f", kbd.keyout); end
    checks++; if (kbd.shift_n !== 1'b1) begin errors++; $display("FAIL midreset_shift_n: got %b want 1", kbd.shift_n); end
    checks++; if (kbd.scan_valid !== 1'b0) begin errors++; $display("FAIL midreset_scan_valid: got %b want 0", kbd.scan_valid); end
    checks++; if (kbd.scan_code !== 8'h00) begin errors++; $display("FAIL midreset_scan_code: got %h want 00", kbd.scan_code); end
    ps2_data = 1'b1;
    @(posedge clk);
    reset_n = 1'b1;
    wait_clk(20);
    kbd.row = 4'd3;
    send(8'h1C);
    @(negedge clk);
    checks++; if (last_code !== 8'h1C) begin errors++; $display("FAIL postreset_scan_code: got %h want 1c", last_code); end
    checks++; if (kbd.keyout !== 6'h1F) begin errors++; $display("FAIL postreset_row3: got %h want 1f", kbd.keyout); end
    checks++; if (kbd.shift_n !== 1'b1) begin errors++; $display("FAIL postreset_shift_n: got %b want 1", kbd.shift_n); end
  endtask

  initial begin
    kbd.row = 4'd0;
    test_reset();
    test_press();
    test_release();
    test_bad_frames();
    test_timeout();
    test_extended();
    test_glitch();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
